ps2_mouse_cmd_tx: RTL
=====================

// Module: ps2_mouse_cmd_tx
// PURPOSE
//  Host-to-device PS/2 transmitter in the 100 MHz mouse domain. Sends one command byte per request to the mouse
//  (0xFF reset, 0xF4 enable reporting, 0xF3 set sample rate, ...). Drives open-drain clk/data through oe controls.
//  Counterpart of the mouse receive/position path that carries positions into the 40 MHz display domain.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  system clock frequency
//  INHIBIT_US   100          time clk is held low before request-to-send
//  TIMEOUT_US   15000        max time from clk release to ack edge
//  FILTER_LEN   4            consecutive equal samples needed to accept a ps2_clk level change
// PORTS
//  clk          in   1  system clock, 100 MHz
//  rst          in   1  reset, synchronous, active-high
//  tx_data      in   8  command byte
//  tx_valid     in   1  request; byte accepted when tx_valid && tx_ready
//  tx_ready     out  1  high only in IDLE
//  tx_done      out  1  1-cycle pulse: byte sent and ACK received
//  tx_err       out  1  1-cycle pulse: NACK or timeout
//  busy         out  1  high whenever state != IDLE
//  ps2_clk_i    in   1  raw pad level of PS/2 clock (async)
//  ps2_data_i   in   1  raw pad level of PS/2 data (async)
//  ps2_clk_oe   out  1  1 = pull clk pad low, 0 = release
//  ps2_data_oe  out  1  1 = pull data pad low, 0 = release
// BEHAVIOUR
//  Reset: state IDLE; tx_ready=1; tx_done=tx_err=busy=0; ps2_clk_oe=ps2_data_oe=0 (both lines released).
//  Reset mid-transfer: lines released and IDLE on the next clk edge; no done/err pulse.
//  Input conditioning: 2-flop synchronizer per line; ps2_clk additionally filtered by FILTER_LEN.
//  Falling edge = filtered clk 1->0, one-cycle strobe. Filtered data is sampled with the clk strobe.
//  Accept: capture tx_data into shift reg; parity = ~^tx_data (odd); frame = {stop=1, parity, d7..d0}.
//  FSM:
//   IDLE     -> INHIBIT on accept.
//   INHIBIT  clk_oe=1 for CLK_FREQ_HZ/1e6*INHIBIT_US cycles (10000 by default); data_oe=1 in the last cycle.
//   REQ      clk_oe=0, data_oe=1 (start bit 0); start timeout counter; falling edge count=0 -> SEND.
//   SEND     on falling edges 1..8 drive d0..d7 LSB first; edge 9 drives parity; edge 10 releases data (stop).
//            data_oe = ~bit in every case.
//   ACK      on falling edge 11 sample data: 0 -> WAIT_IDLE; 1 -> tx_err pulse, -> IDLE.
//   WAIT_IDLE wait until filtered clk=1 and data=1, then tx_done pulse -> IDLE.
//  Timeout: counter runs REQ..ACK. At CLK_FREQ_HZ/1e6*TIMEOUT_US cycles (1_500_000) assert tx_err, release both
//  lines, -> IDLE. WAIT_IDLE has no timeout.
//  tx_done/tx_err pulse in the cycle of the transition to IDLE; tx_ready rises the same cycle.
//  Earliest next accept is the cycle after the pulse. tx_valid is ignored while busy.
//  Counter widths: $clog2(max count + 1); no wrap is reachable.
// STRUCTURE
//  Shared header ps2_defs.vh: FSM state encodings, frame length (11), command constants
//  (PS2_CMD_RESET 8'hFF, PS2_CMD_ENABLE 8'hF4, PS2_CMD_SETRATE 8'hF3), ACK byte 8'hFA.
//  Sub-module ps2_line_filter: sync + FILTER_LEN debounce + falling-edge strobe; reused by the mouse receiver.
// TESTING
//  1 Send 0xF4, device model clocks at 12.5 kHz and ACKs -> clk_oe low 10000 cycles;
//    bits 0,0,1,0,1,1,1,1, parity 0, stop 1; one tx_done; no tx_err.
//  2 Send 0xFF -> parity bit 1; tx_done; tx_ready high again the same cycle as tx_done.
//  3 Device model leaves data high at edge 11 -> tx_err pulse, no tx_done, lines released.
//  4 Device never clocks after REQ -> tx_err exactly 1_500_000 cycles after clk release; both oe=0.
//  5 2-cycle low glitch on ps2_clk during SEND -> ignored; bit index unchanged; frame still correct.
//  6 rst asserted after edge 5 -> next cycle both oe=0, tx_ready=1; a following send of 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_mouse_cmd_tx_pkg.sv
// Shared definitions for the PS/2 mouse host-to-device path: FSM states,
// frame geometry, well-known command bytes and the frame builder.
package ps2_mouse_cmd_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  localparam int FRAME_LEN = 11;

  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_SETRATE = 8'hF3;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // Bits shifted out after the start bit, LSB first: d0..d7, odd parity, stop.
  function automatic logic [9:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus level filter for a PS/2 line: a new level is
// accepted only after FILTER_LEN consecutive equal samples; emits a falling strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic line_f,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_filt;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_filt <= 1'b1;
      r_fall <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= line_i;
      r_s2   <= r_s1;
      r_fall <= 1'b0;
      if (r_s2 != r_filt) begin
        // r_cnt holds how many differing samples preceded this one
        if (r_cnt == CW'(FILTER_LEN - 1)) begin
          r_filt <= r_s2;
          r_fall <= r_filt & ~r_s2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign line_f = r_filt;
  assign fall   = r_fall;

endmodule

// File: rtl/ps2_mouse_cmd_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, shift out
// one byte on device clock falling edges, then check the device ACK bit.
module ps2_mouse_cmd_tx
  import ps2_mouse_cmd_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output state_t     dbg_state
);

  localparam int INH_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int TO_CYC  = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int INH_W   = $clog2(INH_CYC + 1);
  localparam int TO_W    = $clog2(TO_CYC + 1);

  logic             w_clk_f;
  logic             w_clk_fall;
  logic             r_d_s1;
  logic             r_d_s2;
  state_t           r_state;
  logic [9:0]       r_sh;
  logic [3:0]       r_edge;
  logic [INH_W-1:0] r_inh;
  logic [TO_W-1:0]  r_to;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_done;
  logic             r_err;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_clk_i),
    .line_f (w_clk_f),
    .fall   (w_clk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_s1 <= 1'b1;
      r_d_s2 <= 1'b1;
    end else begin
      r_d_s1 <= ps2_data_i;
      r_d_s2 <= r_d_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sh      <= '0;
      r_edge    <= '0;
      r_inh     <= '0;
      r_to      <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_valid) begin
            r_sh      <= ps2_frame(tx_data);
            r_inh     <= '0;
            r_clk_oe  <= 1'b1;
            r_data_oe <= 1'b0;
            r_state   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          r_inh <= r_inh + 1'b1;
          // data goes low one cycle before clk is released (request-to-send)
          if (r_inh == INH_W'(INH_CYC - 2)) r_data_oe <= 1'b1;
          if (r_inh == INH_W'(INH_CYC - 1)) begin
            r_clk_oe <= 1'b0;
            r_to     <= '0;
            r_edge   <= '0;
            r_state  <= ST_REQ;
          end
        end
        ST_REQ, ST_SEND, ST_ACK: begin
          r_to <= r_to + 1'b1;
          if (r_to == TO_W'(TO_CYC - 1)) begin
            r_err     <= 1'b1;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (w_clk_fall) begin
            if (r_state == ST_ACK) begin
              if (r_d_s2) begin
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_WAIT_IDLE;
              end
            end else begin
              // edges 1..10 present d0..d7, parity, stop; the stop bit releases data
              r_data_oe <= ~r_sh[0];
              r_sh      <= {1'b0, r_sh[9:1]};
              r_edge    <= r_edge + 1'b1;
              r_state   <= (r_edge == 4'(FRAME_LEN - 2)) ? ST_ACK : ST_SEND;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (w_clk_f && r_d_s2) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake: a byte is taken on any cycle with tx_valid && tx_ready;
  // tx_ready is high exactly in IDLE and tx_valid is ignored otherwise.
  assign tx_ready    = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign tx_done     = r_done;
  assign tx_err      = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign dbg_state   = r_state;

endmodule
